// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter owner at the execute-stage redirect interface.
// Sequences boot, run, hold and redirect-flush bubbles for the front end.
// Optional build macro PC_MISALIGN_CHK_EN: adds misalign_o and squashes
// misaligned redirect targets to RESET_ADDR.
module pc_ctrl #(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned HOLD_MAX     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
  output logic        hold_o,
`ifdef PC_MISALIGN_CHK_EN
  output logic        misalign_o,
`endif
  output logic        hold_timeout_o
);

  localparam int unsigned FCW = 3;
  localparam int unsigned HCW = 8;

  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LIMIT   = HCW'(HOLD_MAX);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_REDIR = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           hold_timeout_q, hold_timeout_d;
  logic           fetch_valid_q, fetch_valid_d;
  logic           misalign_q, misalign_d;
  logic           redirect;
  logic [31:0]    target;

  // Redirect target selection; misaligned targets fall back to RESET_ADDR when checking is built in
  always_comb begin
    target     = jump_addr_i;
    misalign_d = misalign_q;
`ifdef PC_MISALIGN_CHK_EN
    if (jump_addr_i[1:0] != 2'b00) begin
      target = RESET_ADDR;
      if (redirect) misalign_d = 1'b1;
    end
`endif
  end

  // Next-state, next-pc and combinational flush/hold decode
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    flush_cnt_d    = flush_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    hold_timeout_d = hold_timeout_q;
    flush_o        = 1'b0;
    hold_o         = 1'b0;
    redirect       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        flush_o = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (jump_en_i) begin
          redirect = 1'b1;
        end else if (hold_flag_i) begin
          hold_o     = 1'b1;
          hold_cnt_d = HCW'(1);
          state_d    = ST_HOLD;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_HOLD: begin
        if (jump_en_i) begin
          redirect   = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_flag_i) begin
          hold_o = 1'b1;
          if (hold_cnt_q < HOLD_LIMIT) hold_cnt_d = hold_cnt_q + HCW'(1);
          if ((hold_cnt_q + HCW'(1)) >= HOLD_LIMIT) hold_timeout_d = 1'b1;
        end else begin
          pc_d       = pc_q + 32'd4;
          hold_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_REDIR: begin
        flush_o = 1'b1;
        if (jump_en_i) begin
          redirect = 1'b1;
        end else begin
          pc_d        = pc_q + 32'd4;
          flush_cnt_d = flush_cnt_q - FCW'(1);
          if (flush_cnt_q == FCW'(1)) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Redirect wins over hold and restarts any flush sequence in progress
    if (redirect) begin
      flush_o = 1'b1;
      hold_o  = 1'b0;
      pc_d    = target;
      if (FLUSH_CYCLES > 32'd1) begin
        flush_cnt_d = FLUSH_RELOAD;
        state_d     = ST_REDIR;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  // Fetch is valid in every state except boot
  always_comb begin
    fetch_valid_d = (state_d != ST_BOOT);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_ADDR;
      flush_cnt_q    <= '0;
      hold_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
      fetch_valid_q  <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      flush_cnt_q    <= flush_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_timeout_q <= hold_timeout_d;
      fetch_valid_q  <= fetch_valid_d;
      misalign_q     <= misalign_d;
    end
  end

  assign pc_o           = pc_q;
  assign fetch_valid_o  = fetch_valid_q;
  assign hold_timeout_o = hold_timeout_q;
`ifdef PC_MISALIGN_CHK_EN
  assign misalign_o     = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: two instances (single- and three-cycle flush) driven
// with shared directed and random stimulus, checked against a per-cycle
// behavioural model of the redirect/hold rules.
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold_flag;

  logic [31:0] pc_w [2];
  logic        fv_w [2];
  logic        fl_w [2];
  logic        ho_w [2];
  logic        to_w [2];
  logic        mis_w [2];

  int errors = 0;
  int checks = 0;

  // Model state
  logic [31:0] m_pc   [2];
  bit          m_boot [2];
  int          m_fl   [2];
  int          m_hl   [2];
  bit          m_to   [2];
  bit          m_mis  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_ctrl #(.RESET_ADDR(32'h0000_0000), .FLUSH_CYCLES(1), .HOLD_MAX(16)) u_dut0 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .hold_flag_i(hold_flag), .pc_o(pc_w[0]), .fetch_valid_o(fv_w[0]),
    .flush_o(fl_w[0]), .hold_o(ho_w[0]),
`ifdef PC_MISALIGN_CHK_EN
    .misalign_o(mis_w[0]),
`endif
    .hold_timeout_o(to_w[0])
  );

  pc_ctrl #(.RESET_ADDR(32'h0000_0200), .FLUSH_CYCLES(3), .HOLD_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .hold_flag_i(hold_flag), .pc_o(pc_w[1]), .fetch_valid_o(fv_w[1]),
    .flush_o(fl_w[1]), .hold_o(ho_w[1]),
`ifdef PC_MISALIGN_CHK_EN
    .misalign_o(mis_w[1]),
`endif
    .hold_timeout_o(to_w[1])
  );

`ifndef PC_MISALIGN_CHK_EN
  initial begin
    mis_w[0] = 1'b0;
    mis_w[1] = 1'b0;
  end
`endif

  function automatic int fc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int hm(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic logic [31:0] ra(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'h0000_0200;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, i, $time, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare against the model, advance the model
  task automatic step(input logic r, input logic j, input logic [31:0] a, input logic h);
    logic [31:0] tgt;
    bit          bad;
    rst       = r;
    jump_en   = j;
    jump_addr = a;
    hold_flag = h;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        chk("pc",       i, pc_w[i], m_pc[i]);
        chk("fvalid",   i, 32'(fv_w[i]), 32'(!m_boot[i]));
        chk("flush",    i, 32'(fl_w[i]), 32'(m_boot[i] || (m_fl[i] > 0) || j));
        chk("hold",     i, 32'(ho_w[i]), 32'(!m_boot[i] && !j && (m_fl[i] == 0) && h));
        chk("timeout",  i, 32'(to_w[i]), 32'(m_to[i]));
`ifdef PC_MISALIGN_CHK_EN
        chk("misalign", i, 32'(mis_w[i]), 32'(m_mis[i]));
`endif
      end
      if (!r) begin
        m_pc[i] = ra(i); m_boot[i] = 1; m_fl[i] = 0; m_hl[i] = 0; m_to[i] = 0; m_mis[i] = 0;
      end else if (m_boot[i]) begin
        m_boot[i] = 0;
      end else if (j) begin
        tgt = a;
        bad = (a % 4) != 0;
`ifdef PC_MISALIGN_CHK_EN
        if (bad) begin
          tgt = ra(i);
          m_mis[i] = 1;
        end
`else
        bad = 0;
`endif
        m_pc[i] = tgt;
        m_fl[i] = fc(i) - 1;
        m_hl[i] = 0;
      end else if (m_fl[i] > 0) begin
        m_pc[i] = m_pc[i] + 32'd4;
        m_fl[i] = m_fl[i] - 1;
      end else if (h) begin
        m_hl[i] = m_hl[i] + 1;
        if (m_hl[i] >= hm(i)) m_to[i] = 1;
      end else begin
        m_pc[i] = m_pc[i] + 32'd4;
        m_hl[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic hold_for(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic        rr;
    logic        jj;
    logic        hh;
    logic [31:0] aa;
    int          hold_left;

    rst = 1'b0; jump_en = 1'b0; jump_addr = 32'h0; hold_flag = 1'b0;
    @(posedge clk);
    #1;

    // Reset, boot, sequential fetch from RESET_ADDR
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h44, 1'b1);
    step(1'b1, 1'b1, 32'h44, 1'b1);   // boot cycle ignores inputs
    idle(3);
    chk("pc_after_boot", 0, pc_w[0], 32'h0000_000C);

    // Redirect to 0x40 (dut0 single flush, dut1 three-cycle flush)
    step(1'b1, 1'b1, 32'h40, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 32'h100, 1'b0);
    idle(5);

    // Hold 5 cycles then 16 cycles; dut0 times out only on the long one
    step(1'b1, 1'b1, 32'h20, 1'b0);
    idle(3);
    hold_for(5);
    idle(2);
    chk("no_timeout_5", 0, 32'(to_w[0]), 32'd0);
    hold_for(16);
    idle(2);
    chk("timeout_16", 0, 32'(to_w[0]), 32'd1);

    // Jump and hold together, then reset in the middle of dut1's flush
    step(1'b1, 1'b1, 32'h80, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Misaligned target, restart of a redirect inside REDIR, pc wrap
    step(1'b1, 1'b1, 32'h42, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFF4, 1'b0);
    idle(5);

    // Random traffic
    hold_left = 0;
    for (int n = 0; n < 800; n++) begin
      rr = ($urandom_range(0, 79) != 0);
      jj = ($urandom_range(0, 5) == 0);
      if (hold_left == 0 && $urandom_range(0, 4) == 0) hold_left = $urandom_range(1, 20);
      hh = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      case ($urandom_range(0, 7))
        0:       aa = 32'hFFFF_FFF8;
        1:       aa = $urandom;
        default: aa = $urandom & 32'hFFFF_FFFC;
      endcase
      step(rr, jj, aa, hh);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Control end of the execute-stage redirect interface.
- Consumes jump_en/jump_addr/hold_flag from the execute stage.
- Owns the program counter; drives fetch address, fetch-valid, pipeline flush (if_id, id_ex) and pipeline hold.
- Sits between ex and the if/if_id/id_ex stages; a small FSM sequences boot, run, hold and multi-cycle redirect bubbles.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded by reset.
- FLUSH_CYCLES, 1, number of consecutive cycles flush_o stays high per redirect (1..7); matches instruction-memory read latency.
- HOLD_MAX, 16, consecutive hold cycles after which hold_timeout_o is set (2..255).

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  reset, synchronous, active-low
- jump_en_i  input  1  redirect request from ex, sampled each cycle
- jump_addr_i  input  32  redirect target from ex
- hold_flag_i  input  1  hold request from ex
- pc_o  output  32  fetch address to instruction memory / if_id
- fetch_valid_o  output  1  pc_o is a real fetch
- flush_o  output  1  kill if_id and id_ex contents (load NOP)
- hold_o  output  1  freeze pc, if_id, id_ex
- hold_timeout_o  output  1  sticky: hold exceeded HOLD_MAX cycles

Behaviour:
- Reset (rst=0 at clk edge): pc_o=RESET_ADDR, state=BOOT, flush_cnt=0, hold_cnt=0, hold_timeout_o=0.
- Reset overrides everything, including mid-redirect and mid-hold.
- flush_o and hold_o are combinational from state and current inputs. pc_o, fetch_valid_o and hold_timeout_o are registered.
- States: BOOT, RUN, HOLD, REDIR.
- BOOT:
  - fetch_valid_o=0, flush_o=1, hold_o=0.
  - Inputs are ignored; pc_o stays RESET_ADDR.
  - Next state is RUN. The first valid fetch of RESET_ADDR occurs in the first RUN cycle.
- RUN: fetch_valid_o=1. Priority, highest first:
  - jump_en_i=1:
    - flush_o=1 and hold_o=0 in the same cycle.
    - pc <= jump_addr_i.
    - If FLUSH_CYCLES>1: flush_cnt <= FLUSH_CYCLES-1, state <= REDIR. Otherwise stay in RUN.
    - A concurrent hold_flag_i is ignored.
  - hold_flag_i=1:
    - hold_o=1, flush_o=0, pc unchanged.
    - hold_cnt <= 1, state <= HOLD.
  - Otherwise: pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 32'h0), flush_o=0, hold_o=0.
- HOLD: fetch_valid_o=1, pc frozen.
  - jump_en_i=1: same action as in RUN (redirect wins; hold_o=0 that cycle), hold_cnt <= 0.
  - hold_flag_i=1:
    - hold_o=1.
    - hold_cnt increments, saturating at HOLD_MAX.
    - When hold_cnt reaches HOLD_MAX, hold_timeout_o <= 1 (sticky until reset).
  - hold_flag_i=0: hold_o=0, pc <= pc+4, hold_cnt <= 0, state <= RUN.
- REDIR:
  - flush_o=1 every cycle, hold_o=0, fetch_valid_o=1.
  - pc <= pc+4 each cycle, streaming sequentially from the target.
  - flush_cnt decrements; when flush_cnt==1, state <= RUN.
  - A new jump_en_i in REDIR restarts the redirect: pc <= jump_addr_i, flush_cnt <= FLUSH_CYCLES-1.
  - hold_flag_i is ignored in REDIR.
- Total flush_o pulse per redirect = FLUSH_CYCLES cycles, starting in the cycle jump_en_i is sampled.
- jump_addr_i is used unmodified (no LSB masking) unless the optional feature is compiled in.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - A redirect with jump_addr_i[1:0]!=0 does not load the target. Instead pc <= RESET_ADDR, misalign_o <= 1 (sticky until reset), and the normal flush sequence runs.
- Undefined:
  - No port; the target is loaded as-is.

Test Plan:
- Reset with RESET_ADDR=0, release rst -> 1 BOOT cycle (fetch_valid_o=0, flush_o=1), then pc_o=0,4,8,12 on successive cycles.
- At pc_o=8, pulse jump_en_i=1 with jump_addr_i=32'h40, FLUSH_CYCLES=1 -> flush_o=1 that cycle only; next pc_o=32'h40, then 32'h44.
- FLUSH_CYCLES=3, jump to 32'h100 -> flush_o high 3 cycles; pc_o=100,104,108,10C; state back to RUN after the third flush cycle.
- hold_flag_i high 5 cycles at pc_o=32'h20 -> hold_o=1 for 5 cycles; pc_o stays 32'h20; resumes 32'h24; hold_timeout_o stays 0.
  - Repeat with 16 cycles -> hold_timeout_o=1 and stays 1 after the hold releases.
- jump_en_i and hold_flag_i both 1, target 32'h80 -> hold_o=0, flush_o=1, next pc_o=32'h80. Assert rst=0 mid-REDIR -> pc_o=RESET_ADDR, flush_cnt cleared.
- With PC_MISALIGN_CHK_EN: jump to 32'h42 -> pc_o=RESET_ADDR, misalign_o=1, flush_o=1. Without the macro: pc_o=32'h42.
